// File: rtl/de1_soc_qsys_trace_system_0_fabric_mux_if.sv
// ==========================================================================
// de1_soc_qsys_trace_system_0_fabric_mux_if : streaming beat bus (valid/ready, data, channel, sop/eop). Rev 1.0
// ==========================================================================
`default_nettype none

interface de1_soc_qsys_trace_system_0_fabric_mux_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_WIDTH = 1
);
  logic                     valid;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    data;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic                     startofpacket;
  logic                     endofpacket;

  modport master (output valid, data, channel, startofpacket, endofpacket, input ready);
  modport slave  (input valid, data, channel, startofpacket, endofpacket, output ready);
endinterface

`default_nettype wire

// File: rtl/de1_soc_qsys_trace_system_0_fabric_mux.sv
// ==========================================================================
// de1_soc_qsys_trace_system_0_fabric_mux : 2:1 packet stream mux, macro TRACE_FABRIC_MUX_PACKET_LOCK_EN adds packet lock. Rev 1.0
// ==========================================================================
`default_nettype none

module de1_soc_qsys_trace_system_0_fabric_mux #(
  parameter int DATA_WIDTH       = 8,
  parameter int IN_CHANNEL_WIDTH = 1
) (
  input  wire logic                                clk,
  input  wire logic                                reset_n,
  de1_soc_qsys_trace_system_0_fabric_mux_if.slave  in0,
  de1_soc_qsys_trace_system_0_fabric_mux_if.slave  in1,
  de1_soc_qsys_trace_system_0_fabric_mux_if.master out
);

  logic [1:0]                       w_in_valid;
  logic [1:0]                       w_in_ready;
  logic [1:0]                       w_in_sop;
  logic [1:0]                       w_in_eop;
  logic [1:0][DATA_WIDTH-1:0]       w_in_data;
  logic [1:0][IN_CHANNEL_WIDTH-1:0] w_in_ch;

  logic [1:0]                       r_stg_valid;
  logic [1:0]                       r_stg_sop;
  logic [1:0]                       r_stg_eop;
  logic [1:0][DATA_WIDTH-1:0]       r_stg_data;
  logic [1:0][IN_CHANNEL_WIDTH-1:0] r_stg_ch;

  logic                             w_gnt;
  logic                             w_gnt_valid;
  logic                             w_out_free;
  logic                             w_xfer;
  logic                             w_locked;
  logic                             w_lock_port;
  logic [1:0]                       w_take;

  logic                             r_last_grant;
  logic                             r_out_valid;
  logic                             r_out_sop;
  logic                             r_out_eop;
  logic [DATA_WIDTH-1:0]            r_out_data;
  logic [IN_CHANNEL_WIDTH:0]        r_out_ch;

  assign w_in_valid = {in1.valid, in0.valid};
  assign w_in_sop   = {in1.startofpacket, in0.startofpacket};
  assign w_in_eop   = {in1.endofpacket, in0.endofpacket};
  assign w_in_data  = {in1.data, in0.data};
  assign w_in_ch    = {in1.channel, in0.channel};
  assign in0.ready  = w_in_ready[0];
  assign in1.ready  = w_in_ready[1];

  // A stage can refill in the same cycle its beat moves to the output stage.
  assign w_in_ready = w_take | ~r_stg_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= '0;
      r_stg_sop   <= '0;
      r_stg_eop   <= '0;
      r_stg_data  <= '0;
      r_stg_ch    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_in_valid[i] && w_in_ready[i]) begin
          r_stg_valid[i] <= 1'b1;
          r_stg_sop[i]   <= w_in_sop[i];
          r_stg_eop[i]   <= w_in_eop[i];
          r_stg_data[i]  <= w_in_data[i];
          r_stg_ch[i]    <= w_in_ch[i];
        end else if (w_take[i]) begin
          r_stg_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef TRACE_FABRIC_MUX_PACKET_LOCK_EN
  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_LOCKED = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       r_lock_port;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_IDLE;
      r_lock_port <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && (r_state == c_IDLE)) begin
        r_lock_port <= w_gnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_IDLE) begin
      if (w_xfer && !r_stg_eop[w_gnt]) w_state_nxt = c_LOCKED;
    end else begin
      if (w_xfer && r_stg_eop[w_gnt]) w_state_nxt = c_IDLE;
    end
  end

  assign w_locked    = (r_state == c_LOCKED);
  assign w_lock_port = r_lock_port;
`else
  assign w_locked    = 1'b0;
  assign w_lock_port = 1'b0;
`endif

  // Grant: fixed to the locked port mid-packet, otherwise round-robin.
  always_comb begin
    w_gnt       = 1'b0;
    w_gnt_valid = 1'b0;
    if (w_locked) begin
      w_gnt       = w_lock_port;
      w_gnt_valid = r_stg_valid[w_lock_port];
    end else begin
      w_gnt_valid = |r_stg_valid;
      if (&r_stg_valid) w_gnt = ~r_last_grant;
      else              w_gnt = r_stg_valid[1];
    end
  end

  assign w_out_free = out.ready | ~r_out_valid;
  assign w_xfer     = w_gnt_valid & w_out_free;
  assign w_take     = {w_xfer & w_gnt, w_xfer & ~w_gnt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
    end else if (w_xfer) begin
      r_last_grant <= w_gnt;
      r_out_valid  <= 1'b1;
      r_out_sop    <= r_stg_sop[w_gnt];
      r_out_eop    <= r_stg_eop[w_gnt];
      r_out_data   <= r_stg_data[w_gnt];
      r_out_ch     <= {w_gnt, r_stg_ch[w_gnt]};
    end else if (out.ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out.valid         = r_out_valid;
  assign out.data          = r_out_data;
  assign out.channel       = r_out_ch;
  assign out.startofpacket = r_out_sop;
  assign out.endofpacket   = r_out_eop;

endmodule

`default_nettype wire

// File: tb/tb_de1_soc_qsys_trace_system_0_fabric_mux.sv
// ==========================================================================
// tb_de1_soc_qsys_trace_system_0_fabric_mux : scoreboard bench for the 2:1 trace fabric mux. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_de1_soc_qsys_trace_system_0_fabric_mux;
  localparam int DW = 8;
  localparam int CW = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  de1_soc_qsys_trace_system_0_fabric_mux_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW))   in0_if ();
  de1_soc_qsys_trace_system_0_fabric_mux_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW))   in1_if ();
  de1_soc_qsys_trace_system_0_fabric_mux_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW+1)) out_if ();

  de1_soc_qsys_trace_system_0_fabric_mux #(.DATA_WIDTH(DW), .IN_CHANNEL_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in0     (in0_if),
    .in1     (in1_if),
    .out     (out_if)
  );

  int          errors = 0;
  int          checks = 0;
  int          in0_stall_cycles = 0;
  logic [11:0] exp_q0 [$];   // {sop, eop, channel[1:0], data}
  logic [11:0] exp_q1 [$];
  logic [9:0]  log_q  [$];   // {channel[1:0], data} in output order
  logic [11:0] mon_got;
  logic [7:0]  held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are pushed on acceptance; outputs are matched per source port.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in0_if.valid && in0_if.ready)
        exp_q0.push_back({in0_if.startofpacket, in0_if.endofpacket, 1'b0, in0_if.channel, in0_if.data});
      if (in1_if.valid && in1_if.ready)
        exp_q1.push_back({in1_if.startofpacket, in1_if.endofpacket, 1'b1, in1_if.channel, in1_if.data});
      if (in0_if.valid && !in0_if.ready) in0_stall_cycles++;
      if (out_if.valid && out_if.ready) begin
        mon_got = {out_if.startofpacket, out_if.endofpacket, out_if.channel, out_if.data};
        log_q.push_back({out_if.channel, out_if.data});
        if (out_if.channel[1] == 1'b0) begin
          if (exp_q0.size() == 0) check("sb_unexpected_port0", {20'd0, mon_got}, 32'hFFFF_FFFF);
          else                    check("sb_port0", {20'd0, mon_got}, {20'd0, exp_q0.pop_front()});
        end else begin
          if (exp_q1.size() == 0) check("sb_unexpected_port1", {20'd0, mon_got}, 32'hFFFF_FFFF);
          else                    check("sb_port1", {20'd0, mon_got}, {20'd0, exp_q1.pop_front()});
        end
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] ch, input logic sop, input logic eop);
    if (p == 0) begin
      in0_if.valid = v; in0_if.data = d; in0_if.channel = ch;
      in0_if.startofpacket = sop; in0_if.endofpacket = eop;
    end else begin
      in1_if.valid = v; in1_if.data = d; in1_if.channel = ch;
      in1_if.startofpacket = sop; in1_if.endofpacket = eop;
    end
  endtask

  // Holds the beat until accepted; returns just after the accepting edge.
  task automatic send_beat(input int p, input logic [DW-1:0] d, input logic [CW-1:0] ch,
                           input logic sop, input logic eop);
    int n   = 0;
    bit acc = 1'b0;
    drive(p, 1'b1, d, ch, sop, eop);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (p == 0) ? in0_if.ready : in1_if.ready;
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int p, input logic [DW-1:0] base, input int len, input logic [CW-1:0] ch);
    for (int i = 0; i < len; i++)
      send_beat(p, base + DW'(i), ch, i == 0, i == len - 1);
    drive(p, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || out_if.valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, n < 200}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    check("rst_out_data", {24'd0, out_if.data}, 32'd0);
    check("rst_out_channel", {30'd0, out_if.channel}, 32'd0);
    check("rst_out_sop_eop", {30'd0, out_if.startofpacket, out_if.endofpacket}, 32'd0);
    check("rst_in0_ready", {31'd0, in0_if.ready}, 32'd1);
    check("rst_in1_ready", {31'd0, in1_if.ready}, 32'd1);
    exp_q0.delete();
    exp_q1.delete();
    log_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {30'd0, in1_if.ready, in0_if.ready}, 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    out_if.ready = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single beat on port 0: visible on the second edge after acceptance.
    send_beat(0, 8'h5A, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_after_edge1", {31'd0, out_if.valid}, 32'd0);
    @(negedge clk);
    check("lat_after_edge2", {31'd0, out_if.valid}, 32'd1);
    check("single_data", {24'd0, out_if.data}, 32'h5A);
    check("single_channel", {30'd0, out_if.channel}, 32'd1);
    check("single_sop_eop", {30'd0, out_if.startofpacket, out_if.endofpacket}, 32'd3);
    drain();

    // First contention after reset goes to port 0.
    do_reset();
    fork
      send_pkt(0, 8'h11, 1, 1'b0);
      send_pkt(1, 8'h22, 1, 1'b0);
    join
    drain();
    check("rr_count", log_q.size(), 32'd2);
    check("rr_first", {22'd0, log_q[0]}, {22'd0, 2'b00, 8'h11});
    check("rr_second", {22'd0, log_q[1]}, {22'd0, 2'b10, 8'h22});

    // Port 1 packet A0..A3 starts one cycle before port 0's stream B0..B3.
    log_q.delete();
    in0_stall_cycles = 0;
    fork
      send_pkt(1, 8'hA0, 4, 1'b1);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(0, 8'hB0 + 8'(i), 1'b0, 1'b1, 1'b1);
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
      end
    join
    drain();
    check("lock_count", log_q.size(), 32'd8);
    begin
      logic [9:0] exp_order [8];
`ifdef TRACE_FABRIC_MUX_PACKET_LOCK_EN
      exp_order = '{10'h3A0, 10'h3A1, 10'h3A2, 10'h3A3, 10'h0B0, 10'h0B1, 10'h0B2, 10'h0B3};
`else
      exp_order = '{10'h3A0, 10'h0B0, 10'h3A1, 10'h0B1, 10'h3A2, 10'h0B2, 10'h3A3, 10'h0B3};
`endif
      for (int i = 0; i < 8; i++) check("lock_order", {22'd0, log_q[i]}, {22'd0, exp_order[i]});
    end
`ifdef TRACE_FABRIC_MUX_PACKET_LOCK_EN
    check("lock_in0_stalled", {31'd0, in0_stall_cycles > 0}, 32'd1);
`endif

    // Two simultaneous 3-beat packets.
    log_q.delete();
    fork
      send_pkt(0, 8'h30, 3, 1'b1);
      send_pkt(1, 8'h40, 3, 1'b0);
    join
    drain();
    check("pkt3_count", log_q.size(), 32'd6);
`ifdef TRACE_FABRIC_MUX_PACKET_LOCK_EN
    for (int i = 1; i < 6; i++)
      check("pkt3_contiguous", {31'd0, log_q[i][9]}, {31'd0, (i < 3) ? log_q[0][9] : ~log_q[0][9]});
`else
    for (int i = 1; i < 6; i++)
      check("pkt3_alternate", {31'd0, log_q[i][9]}, {31'd0, ~log_q[i-1][9]});
`endif

    // Output back-pressure while port 0 streams.
    log_q.delete();
    in0_stall_cycles = 0;
    out_if.ready = 1'b0;
    fork
      send_pkt(0, 8'hC0, 6, 1'b0);
      begin
        int n = 0;
        while (!out_if.valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("stall_valid_seen", {31'd0, out_if.valid}, 32'd1);
        held = out_if.data;
        repeat (5) begin
          @(negedge clk);
          check("stall_data_hold", {23'd0, out_if.valid, out_if.data}, {23'd1, held});
        end
        check("stall_in0_ready_low", {31'd0, in0_if.ready}, 32'd0);
        @(posedge clk); #1;
        out_if.ready = 1'b1;
      end
    join
    drain();
    check("stall_count", log_q.size(), 32'd6);
    check("stall_first", {22'd0, log_q[0]}, {22'd0, 2'b00, 8'hC0});
    check("stall_backpressure", {31'd0, in0_stall_cycles > 0}, 32'd1);

    // Reset mid-packet: two beats of a 4-beat packet, then reset.
    send_beat(0, 8'hD0, 1'b0, 1'b1, 1'b0);
    send_beat(0, 8'hD1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_reset();
    send_pkt(1, 8'hE0, 1, 1'b1);
    drain();
    check("post_rst_count", log_q.size(), 32'd1);
    check("post_rst_beat", {22'd0, log_q[0]}, {22'd0, 2'b11, 8'hE0});

    check("final_queues_empty", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
